// File: rtl/bar_fill_writer_if.sv
// bar_fill_writer_if: frame-start input and ping-pong write-port outputs of the bar filler
interface bar_fill_writer_if #(
  parameter int ADDR_W = 10,
  parameter int POS_W = 5
);
  logic frameStart;
  logic we;
  logic [ADDR_W-1:0] wrAddr;
  logic [7:0] wrData;
  logic busy;
  logic frameDone;
  logic [POS_W-1:0] barPos;
  logic overrun;
  modport master(input frameStart, output we, wrAddr, wrData, busy, frameDone, barPos, overrun);
  modport slave(output frameStart, input we, wrAddr, wrData, busy, frameDone, barPos, overrun);
endinterface

// File: rtl/bar_fill_writer.sv
// bar_fill_writer: per-frame raster fill of the back buffer with a scrolling vertical bar
module bar_fill_writer #(
  parameter int COLS = 32,
  parameter int ROWS = 24,
  parameter int ADDR_W = 10,
  parameter int BAR_W = 4,
  parameter logic [7:0] BG_COLOR = 8'h03,
  parameter logic [7:0] BAR_COLOR = 8'hE0,
  parameter int FRAMES_PER_STEP = 2
) (
  input logic vgaclk,
  input logic rst,
  bar_fill_writer_if.master bus
);
  localparam int PW = $clog2(COLS);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int SW = FRAMES_PER_STEP > 1 ? $clog2(FRAMES_PER_STEP) : 1;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] col_q, col_d, cur_q, cur_d, pos_q, pos_d, nxt_col;
  logic [RW-1:0] row_q, row_d, nxt_row;
  logic [SW-1:0] step_q, step_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic we_q, we_d, busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
  logic last, go, adv, wrap;
  // Bar test uses the column offset from the bar's left edge, truncated so the bar wraps
  function automatic logic [7:0] pix(input logic [PW-1:0] c, input logic [PW-1:0] p);
    logic [PW-1:0] d;
    d = c - p;
    return (int'(d) < BAR_W) ? BAR_COLOR : BG_COLOR;
  endfunction
  assign last = row_q == RW'(ROWS - 1) && col_q == PW'(COLS - 1);
  assign go = state_q == IDLE && bus.frameStart;
  assign adv = state_q == FILL && !last;
  assign wrap = state_q == DONE && step_q == SW'(FRAMES_PER_STEP - 1);
  assign nxt_col = col_q + 1'b1;
  assign nxt_row = row_q + RW'(nxt_col == '0);
  // state register
  always_ff @(posedge vgaclk) state_q <= rst ? IDLE : state_d;
  // next-state: IDLE -> FILL on frame start, FILL -> DONE after last pixel, DONE lasts one cycle
  always_comb begin
    state_d = go ? FILL : (state_q == FILL && last) ? DONE : state_q == DONE ? IDLE : state_q;
  end
  // outputs are computed one cycle ahead so every port comes straight from a flop
  always_comb begin
    we_d = state_d == FILL;
    busy_d = state_d == FILL;
    done_d = state_d == DONE;
    col_d = go ? '0 : adv ? nxt_col : col_q;
    row_d = go ? '0 : adv ? nxt_row : row_q;
    cur_d = go ? pos_q : cur_q;
    addr_d = go ? '0 : adv ? addr_q + 1'b1 : addr_q;
    data_d = go ? pix('0, pos_q) : adv ? pix(nxt_col, cur_q) : data_q;
    step_d = wrap ? '0 : state_q == DONE ? step_q + 1'b1 : step_q;
    pos_d = wrap ? pos_q + 1'b1 : pos_q;
    ovr_d = ovr_q | (bus.frameStart && state_q != IDLE);
  end
  // datapath and output registers
  always_ff @(posedge vgaclk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      cur_q <= '0;
      pos_q <= '0;
      step_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      cur_q <= cur_d;
      pos_q <= pos_d;
      step_q <= step_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q <= we_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovr_q <= ovr_d;
    end
  end
  assign bus.we = we_q;
  assign bus.wrAddr = addr_q;
  assign bus.wrData = data_q;
  assign bus.busy = busy_q;
  assign bus.frameDone = done_q;
  assign bus.barPos = pos_q;
  assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_bar_fill_writer.sv
// tb_bar_fill_writer: scoreboard bench for the scrolling-bar back-buffer filler
module tb_bar_fill_writer;
  localparam int COLS = 32, ROWS = 24, ADDR_W = 10, BAR_W = 4, FPS = 2, NPIX = COLS * ROWS;
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [7:0] d;
  } wr_t;
  logic vgaclk = 1'b0;
  logic rst = 1'b1;
  wr_t exp_q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, fills = 0;
  int done_cnt = 0, done_at = -1, first_wr = -1, last_wr = -1, busy_cnt = 0, wr_cnt = 0;
  always #5 vgaclk = ~vgaclk;
  bar_fill_writer_if #(.ADDR_W(ADDR_W), .POS_W(5)) bus();
  bar_fill_writer #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BAR_W(BAR_W),
    .BG_COLOR(8'h03), .BAR_COLOR(8'hE0), .FRAMES_PER_STEP(FPS)
  ) dut (
    .vgaclk(vgaclk),
    .rst(rst),
    .bus(bus)
  );
  always @(posedge vgaclk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(negedge vgaclk) begin
    wr_t e;
    if (bus.we) begin
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (exp_q.size() == 0) check("extra_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.wrAddr), 32'(e.a));
        check("wr_data", 32'(bus.wrData), 32'(e.d));
      end
    end
    if (bus.busy) busy_cnt++;
    if (bus.frameDone) begin
      done_cnt++;
      done_at = cyc;
    end
  end
  task automatic push_frame(input int pos);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        wr_t e;
        logic bar;
        bar = 1'b0;
        for (int k = 0; k < BAR_W; k++) if ((pos + k) % COLS == c) bar = 1'b1;
        e.a = ADDR_W'(r * COLS + c);
        e.d = bar ? 8'hE0 : 8'h03;
        exp_q.push_back(e);
      end
  endtask
  // called just after a rising edge; re_at != 0 re-pulses frameStart that many cycles in
  task automatic fill(input int re_at);
    int t0, dn0, tmo, pos;
    pos = (fills / FPS) % COLS;
    check("barPos_start", 32'(bus.barPos), pos);
    push_frame(pos);
    first_wr = -1;
    busy_cnt = 0;
    dn0 = done_cnt;
    t0 = cyc;
    bus.frameStart = 1'b1;
    tmo = 0;
    while (done_cnt == dn0 && tmo < 1000) begin
      @(posedge vgaclk);
      #1;
      bus.frameStart = re_at != 0 && cyc == t0 + re_at;
      tmo++;
    end
    bus.frameStart = 1'b0;
    check("fill_timeout", tmo < 1000, 1);
    repeat (3) @(posedge vgaclk);
    #1;
    check("first_wr_cycle", first_wr, t0 + 1);
    check("last_wr_cycle", last_wr, t0 + NPIX);
    check("done_cycle", done_at, t0 + NPIX + 1);
    check("done_pulses", done_cnt - dn0, 1);
    check("busy_cycles", busy_cnt, NPIX);
    check("pending_writes", exp_q.size(), 0);
    fills++;
  endtask
  initial begin
    int t0, dn0, wr0;
    bus.frameStart = 1'b0;
    repeat (4) @(posedge vgaclk);
    #1;
    rst = 1'b0;
    @(negedge vgaclk);
    check("rst_we", bus.we, 0);
    check("rst_addr", 32'(bus.wrAddr), 0);
    check("rst_data", 32'(bus.wrData), 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.frameDone, 0);
    check("rst_barPos", 32'(bus.barPos), 0);
    check("rst_overrun", bus.overrun, 0);
    @(posedge vgaclk);
    #1;
    while (cyc < 10) begin
      @(posedge vgaclk);
      #1;
    end
    while (fills < 62) fill(0);
    check("no_overrun_yet", bus.overrun, 0);
    fill(300);
    check("overrun_set", bus.overrun, 1);
    repeat (20) @(posedge vgaclk);
    #1;
    check("overrun_sticky", bus.overrun, 1);
    push_frame((fills / FPS) % COLS);
    t0 = cyc;
    bus.frameStart = 1'b1;
    @(posedge vgaclk);
    #1;
    bus.frameStart = 1'b0;
    while (cyc < t0 + 400) begin
      @(posedge vgaclk);
      #1;
    end
    dn0 = done_cnt;
    rst = 1'b1;
    @(posedge vgaclk);
    #1;
    exp_q.delete();
    rst = 1'b0;
    wr0 = wr_cnt;
    @(negedge vgaclk);
    check("midrst_we", bus.we, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_barPos", 32'(bus.barPos), 0);
    check("midrst_done", bus.frameDone, 0);
    check("midrst_overrun", bus.overrun, 0);
    repeat (400) @(posedge vgaclk);
    #1;
    check("midrst_no_done", done_cnt - dn0, 0);
    check("midrst_no_wr", wr_cnt - wr0, 0);
    fills = 0;
    fill(0);
    rst = 1'b1;
    bus.frameStart = 1'b1;
    @(posedge vgaclk);
    #1;
    rst = 1'b0;
    bus.frameStart = 1'b0;
    wr0 = wr_cnt;
    repeat (10) @(posedge vgaclk);
    #1;
    check("rstfs_no_wr", wr_cnt - wr0, 0);
    check("rstfs_busy", bus.busy, 0);
    check("rstfs_overrun", bus.overrun, 0);
    fills = 0;
    fill(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
